// File: rtl/sys_array_pkg.sv
// Shared types for the systolic array receive path.
// Result lane/row types and the collector FSM states.
package sys_array_pkg;

  localparam int SA_DATA_WIDTH  = 8;
  localparam int SA_ARRAY_MAX_W = 10;

  typedef logic [2*SA_DATA_WIDTH-1:0] lane_t;
  typedef lane_t [SA_ARRAY_MAX_W-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COLLECT
  } state_e;

endpackage

// File: rtl/sys_array_row_fifo.sv
// Result-row FIFO; a write into a full FIFO is accepted only
// when a read happens on the same edge.
module sys_array_row_fifo #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] hold_q;
  logic             push;
  logic             pop;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign pop   = rd_en && !empty;
  assign push  = wr_en && (!full || pop);

  // Last popped row is shown while the FIFO sits empty
  assign rd_data = empty ? hold_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      hold_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold_q <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sys_array_output_collector.sv
// Deskews sys_array_basic column outputs into result rows
// and streams them out through a small row FIFO.
module sys_array_output_collector
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ARRAY_MAX_W = 10,
  parameter int ARRAY_MAX_L = 10,
  parameter int FIFO_DEPTH  = 4,
  parameter int ROW_CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [ROW_CNT_W-1:0]         num_rows,
  input  logic [$clog2(ARRAY_MAX_L)-1:0] array_w_l,
  input  logic [$clog2(ARRAY_MAX_W)-1:0] array_w_w,
  input  logic [ARRAY_MAX_W-1:0][2*DATA_WIDTH-1:0] output_data,
  output logic [ARRAY_MAX_W-1:0][2*DATA_WIDTH-1:0] row_data,
  output logic                         row_valid,
  input  logic                         row_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow
);

  localparam int LW = 2*DATA_WIDTH;
  localparam int WW = $clog2(ARRAY_MAX_W);
  localparam int CW = $clog2(ARRAY_MAX_L + ARRAY_MAX_W);

  state_e               state;
  logic [CW-1:0]        lat_cnt;
  logic [ROW_CNT_W-1:0] num_rows_q;
  logic [ROW_CNT_W-1:0] rows_left;
  logic [WW-1:0]        w_w_q;

  logic [ARRAY_MAX_W-1:0][LW-1:0] aligned;
  logic [ARRAY_MAX_W-1:0][LW-1:0] wr_row;
  logic wr_en;
  logic rd_en;
  logic fifo_full;
  logic fifo_empty;

  // Lane i is late by i cycles; pad it up to the last lane
  for (genvar i = 0; i < ARRAY_MAX_W; i++) begin : g_lane
    localparam int D = ARRAY_MAX_W - 1 - i;
    if (D == 0) begin : g_pass
      assign aligned[i] = output_data[i];
    end else begin : g_dly
      logic [D-1:0][LW-1:0] sr;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sr <= '0;
        end else begin
          sr[0] <= output_data[i];
          for (int j = 1; j < D; j++) sr[j] <= sr[j-1];
        end
      end
      assign aligned[i] = sr[D-1];
    end
  end

  always_comb begin
    wr_row = '0;
    for (int i = 0; i < ARRAY_MAX_W; i++) begin
      if (WW'(i) <= w_w_q) wr_row[i] = aligned[i];
    end
  end

  assign wr_en     = (state == COLLECT);
  assign row_valid = !fifo_empty;
  assign rd_en     = row_valid && row_ready;

  sys_array_row_fifo #(
    .WIDTH (ARRAY_MAX_W*LW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_row),
    .rd_en   (rd_en),
    .rd_data (row_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      num_rows_q <= '0;
      rows_left  <= '0;
      w_w_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_en && fifo_full && !rd_en) overflow <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            num_rows_q <= (num_rows == '0) ? ROW_CNT_W'(1) : num_rows;
            w_w_q      <= array_w_w;
            lat_cnt    <= CW'(array_w_l) + CW'(ARRAY_MAX_W - 1);
            overflow   <= 1'b0;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          // Leave on the edge the count hits 0 so A_0 is a write
          if (lat_cnt <= CW'(1)) begin
            rows_left <= num_rows_q;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          rows_left <= rows_left - 1'b1;
          if (rows_left == ROW_CNT_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_array_output_collector.sv
// Bench: skewed array model driving the collector, rows
// checked against a scoreboard queue of expected rows.
module tb_sys_array_output_collector;
  import sys_array_pkg::*;

  localparam int NW = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] num_rows;
  logic [3:0] array_w_l;
  logic [3:0] array_w_w;
  row_t       od;
  row_t       row_data;
  logic       row_valid;
  logic       row_ready;
  logic       busy;
  logic       done;
  logic       overflow;

  sys_array_output_collector dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .num_rows    (num_rows),
    .array_w_l   (array_w_l),
    .array_w_w   (array_w_w),
    .output_data (od),
    .row_data    (row_data),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_start = -1000;
  int   cur_wl = 0;
  int   cur_ww = 0;
  int   cur_nvec = 0;
  int   done_cnt = 0;
  int   rows_seen = 0;
  row_t last_exp = '0;
  row_t sb_q[$];

  typedef struct {
    int wl;
    int ww;
    int nr;
    int exp_lat;
    int exp_rows;
  } vec_t;

  function automatic lane_t val(int i, int k);
    return lane_t'(5 + 6*i + 12*k);
  endfunction

  function automatic row_t exp_row(int ww, int k);
    row_t r;
    r = '0;
    for (int i = 0; i < NW; i++) if (i <= ww) r[i] = val(i, k);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Array model: lane i of vector k lands at edge T+wl+i+k+1
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NW; i++) begin
      int k;
      k = cyc - t_start - cur_wl - i;
      if (k >= 0 && k < cur_nvec && i <= cur_ww) od[i] = val(i, k);
      else od[i] = lane_t'($urandom);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        done_cnt++;
        checks++;
        if (busy) begin
          errors++;
          $display("FAIL busy_at_done: got 1 expected 0");
        end
      end
      if (row_valid && row_ready) begin
        checks++;
        rows_seen++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_row: got %0h expected none",
                   row_data);
        end else begin
          last_exp = sb_q.pop_front();
          if (row_data !== last_exp) begin
            errors++;
            $display("FAIL row: got %0h expected %0h",
                     row_data, last_exp);
          end
        end
      end
    end
  end

  // mode 0: always ready, 1: stalled until done, 2: ready after A_3
  task automatic run_batch(input vec_t v, input int mode,
                           input bit restart, input int exp_ovf,
                           input bit chk_row0, input row_t row0);
    int d0, r0, lat;
    bit fin;
    d0 = done_cnt;
    r0 = rows_seen;
    lat = -1;
    fin = 0;
    @(posedge clk);
    #2;
    array_w_l = 4'(v.wl);
    array_w_w = 4'(v.ww);
    num_rows  = 8'(v.nr);
    row_ready = (mode == 0);
    cur_wl = v.wl;
    cur_ww = v.ww;
    cur_nvec = (v.nr == 0) ? 1 : v.nr;
    t_start = cyc + 1;
    start = 1'b1;
    for (int k = 0; k < v.exp_rows; k++) sb_q.push_back(exp_row(v.ww, k));
    for (int c = 0; c < 150 && !fin; c++) begin
      tick();
      if (c == 0) begin
        start = 1'b0;
        chk("ovf_clear_on_start", 160'(overflow), 160'(0));
      end
      if (lat < 0 && row_valid) begin
        lat = c;
        if (chk_row0) chk("row0_const", row_data, row0);
      end
      if (restart && c == v.wl + 11) start = 1'b1;
      if (restart && c == v.wl + 12) start = 1'b0;
      if (mode == 2 && c == v.wl + 13) row_ready = 1'b1;
      if (done_cnt != d0) fin = 1;
    end
    chk("done_seen", 160'(fin), 160'(1));
    if (mode == 1) begin
      chk("overflow_set", 160'(overflow), 160'(1));
      chk("valid_while_stalled", 160'(row_valid), 160'(1));
      repeat (3) tick();
      row_ready = 1'b1;
    end
    fin = 0;
    for (int c = 0; c < 60 && !fin; c++) begin
      tick();
      if (sb_q.size() == 0 && !row_valid) fin = 1;
    end
    chk("drained", 160'(fin), 160'(1));
    repeat (4) tick();
    chk("latency", 160'(lat), 160'(v.exp_lat));
    chk("done_once", 160'(done_cnt - d0), 160'(1));
    chk("row_count", 160'(rows_seen - r0), 160'(v.exp_rows));
    chk("overflow", 160'(overflow), 160'(exp_ovf));
    chk("busy_idle", 160'(busy), 160'(0));
    chk("hold_last", row_data, last_exp);
  endtask

  vec_t vecs[6];
  row_t row0;
  vec_t bp;
  int   d0;

  initial begin
    vecs[0] = '{wl: 1, ww: 4, nr: 5, exp_lat: 11, exp_rows: 5};
    vecs[1] = '{wl: 0, ww: 2, nr: 3, exp_lat: 10, exp_rows: 3};
    vecs[2] = '{wl: 3, ww: 9, nr: 4, exp_lat: 13, exp_rows: 4};
    vecs[3] = '{wl: 9, ww: 9, nr: 2, exp_lat: 19, exp_rows: 2};
    vecs[4] = '{wl: 2, ww: 6, nr: 0, exp_lat: 12, exp_rows: 1};
    vecs[5] = '{wl: 0, ww: 0, nr: 1, exp_lat: 10, exp_rows: 1};
    row0 = '0;
    row0[0] = 16'd5;
    row0[1] = 16'd11;
    row0[2] = 16'd17;
    row0[3] = 16'd23;
    row0[4] = 16'd29;

    reset_n = 1'b0;
    start = 1'b0;
    num_rows = '0;
    array_w_l = '0;
    array_w_w = '0;
    row_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_valid", 160'(row_valid), 160'(0));
    chk("rst_done", 160'(done), 160'(0));
    chk("rst_ovf", 160'(overflow), 160'(0));
    chk("rst_data", row_data, 160'(0));
    reset_n = 1'b1;
    repeat (2) tick();

    for (int n = 0; n < 6; n++)
      run_batch(vecs[n], 0, 1'b0, 0, n == 0, row0);

    bp = '{wl: 1, ww: 4, nr: 6, exp_lat: 11, exp_rows: 4};
    run_batch(bp, 1, 1'b0, 1, 1'b0, row0);

    // Reset mid-WAIT; the start also clears the old overflow
    d0 = done_cnt;
    @(posedge clk);
    #2;
    array_w_l = 4'd5;
    array_w_w = 4'd9;
    num_rows = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clears_ovf", 160'(overflow), 160'(0));
    chk("busy_in_wait", 160'(busy), 160'(1));
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("async_busy", 160'(busy), 160'(0));
    chk("async_valid", 160'(row_valid), 160'(0));
    chk("async_done", 160'(done), 160'(0));
    chk("async_ovf", 160'(overflow), 160'(0));
    chk("async_data", row_data, 160'(0));
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (40) tick();
    chk("no_row_after_rst", 160'(row_valid), 160'(0));
    chk("no_done_after_rst", 160'(done_cnt - d0), 160'(0));

    bp = '{wl: 1, ww: 4, nr: 6, exp_lat: 11, exp_rows: 6};
    run_batch(bp, 2, 1'b0, 0, 1'b0, row0);

    bp = '{wl: 1, ww: 4, nr: 4, exp_lat: 11, exp_rows: 4};
    run_batch(bp, 0, 1'b1, 0, 1'b0, row0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
